// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the camera frame-capture block.
package cam_pkg;

  localparam int H_PIXELS     = 160;
  localparam int V_LINES      = 120;
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam int ADDR_W       = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/cam_capture_rgb565_to_rgb332.sv
// Pure combinational RGB565 (two camera bytes) to RGB332 truncation.
module rgb565_to_rgb332 (
  input  logic [7:0] byte_hi,
  input  logic [7:0] byte_lo,
  output logic [7:0] rgb332
);

  // byte_hi = {R[4:0], G[5:3]}, byte_lo = {G[2:0], B[4:0]}
  assign rgb332 = {byte_hi[7:5], byte_hi[2:0], byte_lo[4:3]};

  // Low-order colour bits are dropped by design.
  logic unused_bits;
  assign unused_bits = ^{byte_hi[4:3], byte_lo[7:5], byte_lo[2:0]};

endmodule

// File: rtl/cam_capture.sv
// Single-frame capture from an RGB565 byte-serial camera into an RGB332 frame buffer.
module cam_capture #(
  parameter int H_PIXELS = cam_pkg::H_PIXELS,
  parameter int V_LINES  = cam_pkg::V_LINES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 px_data,
  output logic [cam_pkg::ADDR_W-1:0] addr,
  output logic [7:0]                 mem_data,
  output logic                       wr,
  output logic                       busy,
  output logic                       done,
  output logic                       frame_err
);

  import cam_pkg::*;

  localparam int FRAME_LIMIT = H_PIXELS * V_LINES;
  localparam int COL_W       = $clog2(H_PIXELS + 1);
  localparam int LINE_W      = $clog2(V_LINES + 2);
  localparam int WCNT_W      = $clog2(FRAME_LIMIT + 1);

  state_e              state_q, state_d;
  logic                init_q, init_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic                phase_q, phase_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [7:0]          byte_hi_q, byte_hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          mem_q, mem_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [7:0] pixel;
  logic       init_rise, vsync_fall, vsync_rise, href_fall;
  logic       pixel_fits;

  rgb565_to_rgb332 u_conv (
    .byte_hi (byte_hi_q),
    .byte_lo (px_data),
    .rgb332  (pixel)
  );

  assign init_rise  = init & ~init_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign vsync_rise = vsync & ~vsync_q;
  assign href_fall  = ~href & href_q;
  assign pixel_fits = (col_q < COL_W'(H_PIXELS)) && (line_q < LINE_W'(V_LINES)) &&
                      (wcnt_q < WCNT_W'(FRAME_LIMIT));

  always_comb begin
    state_d   = state_q;
    init_d    = init;
    vsync_d   = vsync;
    href_d    = href;
    phase_d   = phase_q;
    col_d     = col_q;
    line_d    = line_q;
    wcnt_d    = wcnt_q;
    byte_hi_d = byte_hi_q;
    addr_d    = addr_q;
    mem_d     = mem_q;
    wr_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (init_rise) begin
          state_d = WAIT_SOF;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      WAIT_SOF: begin
        if (vsync_fall) begin
          state_d = CAPTURE;
          phase_d = 1'b0;
          col_d   = '0;
          line_d  = '0;
          wcnt_d  = '0;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (line_q != LINE_W'(V_LINES)) err_d = 1'b1;
        end else if (href) begin
          if (!phase_q) begin
            byte_hi_d = px_data;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pixel_fits) begin
              wr_d   = 1'b1;
              addr_d = ADDR_W'(wcnt_q);
              mem_d  = pixel;
              wcnt_d = wcnt_q + WCNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
            // Column saturates at H_PIXELS; overlong lines are already flagged above.
            if (col_q != COL_W'(H_PIXELS)) col_d = col_q + COL_W'(1);
          end
        end else if (href_fall) begin
          phase_d = 1'b0;
          col_d   = '0;
          if (col_q != '0 && line_q != LINE_W'(V_LINES + 1)) line_d = line_q + LINE_W'(1);
          if (phase_q || col_q != COL_W'(H_PIXELS)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      phase_q   <= 1'b0;
      col_q     <= '0;
      line_q    <= '0;
      wcnt_q    <= '0;
      byte_hi_q <= '0;
      addr_q    <= '0;
      mem_q     <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      line_q    <= line_d;
      wcnt_q    <= wcnt_d;
      byte_hi_q <= byte_hi_d;
      addr_q    <= addr_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign addr      = addr_q;
  assign mem_data  = mem_q;
  assign wr        = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: random and directed frames against a byte-stream model.
module tb_cam_capture;

  localparam int H = 160;
  localparam int V = 120;
  localparam int FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  px_data = 8'h00;
  logic [14:0] addr;
  logic [7:0]  mem_data;
  logic        wr, busy, done, frame_err;

  cam_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .vsync     (vsync),
    .href      (href),
    .px_data   (px_data),
    .addr      (addr),
    .mem_data  (mem_data),
    .wr        (wr),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [22:0] obs_q[$];
  logic [22:0] exp_q[$];
  bit          exp_err;
  logic [7:0]  q_bytes[$];
  int          q_lens[$];
  int          init_at_line = -1;
  int          done_rises = 0;
  logic        done_prev = 1'b0;

  // Observed writes and done edges, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr === 1'b1) obs_q.push_back({addr, mem_data});
    if (done === 1'b1 && done_prev !== 1'b1) done_rises++;
    done_prev = done;
  end

  function automatic logic [7:0] to332(int b0, int b1);
    int r5, g6, b5;
    r5 = b0 / 8;
    g6 = (b0 % 8) * 8 + b1 / 32;
    b5 = b1 % 32;
    return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + (b5 / 8));
  endfunction

  // Expected writes and error flag from the line list: pixels are byte pairs,
  // only the first H pixels of the first V non-empty lines are stored.
  function automatic void build_model();
    int k, lines, cnt, npx;
    exp_q.delete();
    exp_err = 0;
    k = 0; lines = 0; cnt = 0;
    for (int l = 0; l < q_lens.size(); l++) begin
      npx = q_lens[l] / 2;
      if (q_lens[l] % 2 != 0) exp_err = 1;
      if (npx != H) exp_err = 1;
      for (int p = 0; p < npx; p++) begin
        if (p < H && lines < V && cnt < FRAME) begin
          exp_q.push_back({15'(cnt), to332(int'(q_bytes[k + 2*p]), int'(q_bytes[k + 2*p + 1]))});
          cnt++;
        end else begin
          exp_err = 1;
        end
      end
      if (npx > 0) lines++;
      k += q_lens[l];
    end
    if (lines != V) exp_err = 1;
  endfunction

  function automatic int seq_mismatch(output int first);
    int n, nb;
    nb = 0; first = -1;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        nb++;
      end
    end
    return nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    init = 1'b1; tick();
    init = 1'b0; tick();
  endtask

  task automatic sof();
    vsync = 1'b1; repeat (3) tick();
    vsync = 1'b0; repeat (2) tick();
  endtask

  task automatic eof();
    href = 1'b0; tick();
    vsync = 1'b1; repeat (3) tick();
  endtask

  task automatic play_lines(input bit final_gap);
    int k;
    k = 0;
    for (int l = 0; l < q_lens.size(); l++) begin
      for (int i = 0; i < q_lens[l]; i++) begin
        href = 1'b1; px_data = q_bytes[k]; k++; tick();
      end
      if (final_gap || l != q_lens.size() - 1) begin
        href = 1'b0; px_data = 8'($urandom);
        if (l == init_at_line) init = 1'b1;
        tick();
        init = 1'b0;
      end
    end
  endtask

  task automatic fill_uniform(int nlines, int len, logic [7:0] b0, logic [7:0] b1);
    q_lens.delete(); q_bytes.delete();
    for (int l = 0; l < nlines; l++) begin
      q_lens.push_back(len);
      for (int i = 0; i < len; i++) q_bytes.push_back((i % 2 == 0) ? b0 : b1);
    end
  endtask

  task automatic fill_random_line(int len);
    q_lens.push_back(len);
    for (int i = 0; i < len; i++) q_bytes.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (addr !== 15'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", addr); end
    total++; if (mem_data !== 8'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", mem_data); end
    total++; if ({wr, busy, done, frame_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {wr, busy, done, frame_err}); end
    rst = 1'b0; repeat (2) tick();
    total++; if ({wr, busy, done} !== 3'b000) begin bad++; $display("FAIL post_reset_flags: got %b want 000", {wr, busy, done}); end
    $display("reset: addr=%0d data=%0h flags=%b", addr, mem_data, {wr, busy, done, frame_err});
  endtask

  task automatic test_color_pixels();
    obs_q.delete();
    arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL color_busy: got %b want 1", busy); end
    q_lens.delete(); q_bytes.delete();
    q_lens.push_back(4);
    q_bytes.push_back(8'h07); q_bytes.push_back(8'hE0); q_bytes.push_back(8'h00); q_bytes.push_back(8'h1F);
    build_model();
    sof(); play_lines(1'b1); eof();
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL color_count: got %0d want 2", obs_q.size());
    end else if (obs_q[0] !== {15'd0, 8'h1C} || obs_q[1] !== {15'd1, 8'h03}) begin
      bad++; $display("FAIL color_pixels: got %h %h want %h %h", obs_q[0], obs_q[1], {15'd0, 8'h1C}, {15'd1, 8'h03});
    end
    total++; if ({done, frame_err, busy} !== 3'b110) begin bad++; $display("FAIL color_status: got done/err/busy=%b want 110", {done, frame_err, busy}); end
    $display("color: writes=%0d done=%b err=%b", obs_q.size(), done, frame_err);
  endtask

  task automatic test_random_frames();
    int first, nb;
    for (int f = 0; f < 6; f++) begin
      obs_q.delete();
      q_lens.delete(); q_bytes.delete();
      for (int l = 0; l < int'($urandom_range(1, 5)); l++) fill_random_line(int'($urandom_range(1, 13)));
      build_model();
      arm();
      total++; if ({busy, done, frame_err} !== 3'b100) begin bad++; $display("FAIL rand_arm%0d: got busy/done/err=%b want 100", f, {busy, done, frame_err}); end
      sof(); play_lines(1'b1); eof();
      nb = seq_mismatch(first);
      total++; if (obs_q.size() != exp_q.size() || nb != 0) begin bad++; $display("FAIL rand_writes%0d: got n=%0d bad=%0d first=%0d want n=%0d", f, obs_q.size(), nb, first, exp_q.size()); end
      total++; if (done !== 1'b1 || frame_err !== exp_err) begin bad++; $display("FAIL rand_status%0d: got done=%b err=%b want 1 %b", f, done, frame_err, exp_err); end
      $display("random frame %0d: lines=%0d writes=%0d err=%b", f, q_lens.size(), obs_q.size(), frame_err);
    end
  endtask

  task automatic test_back_to_back_init();
    int first, nb, rises0;
    obs_q.delete();
    fill_uniform(V, 2 * H, 8'hF8, 8'h00);
    build_model();
    rises0 = done_rises;
    arm();
    sof();
    init_at_line = V / 2;
    play_lines(1'b1);
    init_at_line = -1;
    eof();
    nb = seq_mismatch(first);
    total++; if (obs_q.size() != FRAME) begin bad++; $display("FAIL red_count: got %0d want %0d", obs_q.size(), FRAME); end
    total++; if (nb != 0 || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL red_seq: got %0d bad entries first=%0d want 0", nb, first); end
    total++; if ({done, frame_err, busy} !== 3'b100) begin bad++; $display("FAIL red_status: got done/err/busy=%b want 100", {done, frame_err, busy}); end
    total++; if (done_rises - rises0 != 1) begin bad++; $display("FAIL red_done_once: got %0d want 1", done_rises - rises0); end
    // A further frame after DONE must not be captured without a new init.
    obs_q.delete();
    fill_uniform(2, 2 * H, 8'hF8, 8'h00);
    sof(); play_lines(1'b1); eof();
    total++; if (obs_q.size() != 0 || done !== 1'b1) begin bad++; $display("FAIL red_no_rearm: got writes=%0d done=%b want 0 1", obs_q.size(), done); end
    $display("red frame: writes=%0d done=%b err=%b", FRAME, done, frame_err);
  endtask

  task automatic test_reset_mid_capture();
    int first, nb, n_before;
    obs_q.delete();
    q_lens.delete(); q_bytes.delete();
    for (int l = 0; l < 31; l++) fill_random_line(2 * H);
    fill_random_line(80);
    build_model();
    arm(); sof();
    play_lines(1'b0);
    #2;
    total++; if (wr !== 1'b1 || addr !== 15'd4999) begin bad++; $display("FAIL rstmid_pre: got wr=%b addr=%0d want 1 4999", wr, addr); end
    rst = 1'b1;
    #1;
    total++; if ({wr, busy, done, frame_err} !== 4'b0000 || addr !== 15'd0 || mem_data !== 8'd0) begin
      bad++; $display("FAIL rstmid_async: got flags=%b addr=%0d data=%0h want 0000 0 0", {wr, busy, done, frame_err}, addr, mem_data);
    end
    n_before = obs_q.size();
    nb = seq_mismatch(first);
    total++; if (n_before != 4999 || nb != 0) begin bad++; $display("FAIL rstmid_seq: got n=%0d bad=%0d first=%0d want 4999 0", n_before, nb, first); end
    for (int i = 0; i < 30; i++) begin
      if (i == 10) rst = 1'b0;
      href = 1'b1; px_data = 8'($urandom); tick();
    end
    href = 1'b0; tick();
    total++; if (obs_q.size() != n_before || busy !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: got writes=%0d busy=%b want %0d 0", obs_q.size(), busy, n_before); end
    $display("reset mid-capture: writes=%0d busy=%b", obs_q.size(), busy);
  endtask

  task automatic test_mid_frame_arm_long_line();
    int first, nb, maxa, n0;
    n0 = obs_q.size();
    arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midarm_busy: got %b want 1", busy); end
    q_lens.delete(); q_bytes.delete();
    for (int l = 0; l < 3; l++) fill_random_line(40);
    play_lines(1'b1);
    total++; if (obs_q.size() != n0) begin bad++; $display("FAIL midarm_nowr: got %0d want %0d", obs_q.size() - n0, 0); end
    obs_q.delete();
    q_lens.delete(); q_bytes.delete();
    fill_random_line(340);
    for (int l = 1; l < V; l++) fill_random_line(2 * H);
    build_model();
    sof(); play_lines(1'b1); eof();
    nb = seq_mismatch(first);
    maxa = 0;
    foreach (obs_q[i]) if (int'(obs_q[i][22:8]) > maxa) maxa = int'(obs_q[i][22:8]);
    total++; if (obs_q.size() != FRAME) begin bad++; $display("FAIL long_count: got %0d want %0d", obs_q.size(), FRAME); end
    total++; if (nb != 0 || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL long_seq: got %0d bad entries first=%0d want 0", nb, first); end
    total++; if (maxa > FRAME - 1) begin bad++; $display("FAIL long_maxaddr: got %0d want <= %0d", maxa, FRAME - 1); end
    total++; if ({done, frame_err, busy} !== 3'b110) begin bad++; $display("FAIL long_status: got done/err/busy=%b want 110", {done, frame_err, busy}); end
    $display("long-line frame: writes=%0d maxaddr=%0d err=%b", obs_q.size(), maxa, frame_err);
  endtask

  initial begin
    test_reset();
    test_color_pixels();
    test_random_frames();
    test_back_to_back_init();
    test_reset_mid_capture();
    test_mid_frame_arm_long_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
